// File: rtl/risc16_dmem_responder.sv
// RISC16 data-memory responder: local word RAM with same-cycle reads, plus an I/O page
// holding a free-running cycle counter, a compare timer and an output stream FIFO.
module risc16_dmem_responder #(
    parameter int RAM_AW     = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] daddr,
    input  logic [15:0] ddout,
    input  logic        doe,
    input  logic        dwe,
    output logic [15:0] ddin,
    output logic        out_valid,
    output logic [15:0] out_data,
    input  logic        out_ready,
    output logic        timer_irq
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [15:0]       ram [2**RAM_AW];
    logic [RAM_AW-1:0] ram_idx;

    logic        io_sel;
    logic        io_ok;
    logic [1:0]  io_reg;
    logic        unused_addr_bit;

    logic [15:0] cycle;
    logic [15:0] tcmp;
    logic        timer_hit;
    logic        overflow;

    logic [15:0]   fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic [2:0]    count3;
    logic          full;
    logic          empty;
    logic [15:0]   status;

    logic wr_ram;
    logic wr_tcmp;
    logic wr_status;
    logic push;
    logic pop;
    logic accept;

    assign unused_addr_bit = daddr[0];

    // Anything outside the top 4 KB is RAM; upper address bits simply alias.
    assign io_sel  = (daddr[15:12] == 4'hF);
    assign io_ok   = io_sel && (daddr[11:3] == 9'd0);
    assign io_reg  = daddr[2:1];
    assign ram_idx = daddr[RAM_AW:1];

    assign full   = (count == CW'(FIFO_DEPTH));
    assign empty  = (count == '0);
    assign count3 = 3'(count);
    assign status = {9'd0, count3, overflow, empty, full, timer_hit};

    assign wr_ram    = dwe && !io_sel;
    assign wr_tcmp   = dwe && io_ok && (io_reg == 2'd1);
    assign wr_status = dwe && io_ok && (io_reg == 2'd2);
    assign push      = dwe && io_ok && (io_reg == 2'd3);
    assign pop       = out_valid && out_ready;
    // A full FIFO still takes a push when the sink frees a slot in the same cycle.
    assign accept    = push && (!full || pop);

    assign out_valid = !empty;
    assign out_data  = fifo_mem[head];
    assign timer_irq = timer_hit;

    always_comb begin
        ddin = 16'h0000;
        if (doe) begin
            if (io_sel) begin
                if (io_ok) begin
                    case (io_reg)
                        2'd0:    ddin = cycle;
                        2'd1:    ddin = tcmp;
                        2'd2:    ddin = status;
                        default: ddin = 16'h0000;
                    endcase
                end
            end else begin
                ddin = ram[ram_idx];
            end
        end
    end

    // RAM keeps its contents across reset; a simultaneous read sees the old word.
    always_ff @(posedge clk) begin
        if (wr_ram) begin
            ram[ram_idx] <= ddout;
        end
    end

    // Compare uses the TCMP value held before any write this cycle; a hit beats a W1C.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle     <= 16'h0000;
            tcmp      <= 16'hFFFF;
            timer_hit <= 1'b0;
        end else begin
            cycle     <= cycle + 16'd1;
            timer_hit <= (cycle == tcmp) || (timer_hit && !(wr_status && ddout[0]));
            if (wr_tcmp) begin
                tcmp <= ddout;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem[i] <= 16'h0000;
            end
        end else begin
            if (accept) begin
                fifo_mem[tail] <= ddout;
                tail           <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            count    <= count + CW'(accept) - CW'(pop);
            overflow <= (push && full && !pop) || (overflow && !(wr_status && ddout[3]));
        end
    end

endmodule

// File: tb/tb_risc16_dmem_responder.sv
// Self-checking bench for risc16_dmem_responder: directed scenarios followed by random
// traffic, all compared against a queue/array reference model of the memory map.
module tb_risc16_dmem_responder;

    localparam int RAM_AW     = 10;
    localparam int FIFO_DEPTH = 4;
    localparam int RAM_WORDS  = 1 << RAM_AW;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] daddr;
    logic [15:0] ddout;
    logic        doe;
    logic        dwe;
    logic [15:0] ddin;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ready;
    logic        timer_irq;

    int assert_count = 0;
    int fail_count   = 0;

    int          m_cycle;
    logic [15:0] m_tcmp;
    bit          m_hit;
    bit          m_ovf;
    logic [15:0] m_fifo [$];
    logic [15:0] m_ram [RAM_WORDS];
    bit          m_known [RAM_WORDS];

    risc16_dmem_responder #(.RAM_AW(RAM_AW), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .daddr     (daddr),
        .ddout     (ddout),
        .doe       (doe),
        .dwe       (dwe),
        .ddin      (ddin),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .timer_irq (timer_irq)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        assert_count++;
        assert (obs === exp) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit is_io(input logic [15:0] a);
        return a[15:12] == 4'hF;
    endfunction

    function automatic bit io_valid(input logic [15:0] a);
        return is_io(a) && (a[11:3] == 9'd0);
    endfunction

    function automatic int ram_word(input logic [15:0] a);
        return int'(a[RAM_AW:1]);
    endfunction

    function automatic logic [15:0] model_status();
        logic [2:0] c;
        c = 3'(m_fifo.size());
        return {9'd0, c, m_ovf, m_fifo.size() == 0, m_fifo.size() == FIFO_DEPTH, m_hit};
    endfunction

    // Returns 0 when the expected value is unknown (never-written RAM word).
    function automatic bit model_read(input logic [15:0] a, output logic [15:0] v);
        v = 16'h0000;
        if (is_io(a)) begin
            if (io_valid(a)) begin
                case (a[2:1])
                    2'd0:    v = 16'(m_cycle);
                    2'd1:    v = m_tcmp;
                    2'd2:    v = model_status();
                    default: v = 16'h0000;
                endcase
            end
            return 1'b1;
        end
        v = m_ram[ram_word(a)];
        return m_known[ram_word(a)];
    endfunction

    task automatic model_reset();
        m_cycle = 0;
        m_tcmp  = 16'hFFFF;
        m_hit   = 1'b0;
        m_ovf   = 1'b0;
        m_fifo.delete();
    endtask

    task automatic model_edge(input logic [15:0] a, input logic [15:0] d, input logic we, input logic ready);
        bit ok;
        bit ovf_set;
        logic [1:0] r;
        ok      = io_valid(a);
        r       = a[2:1];
        ovf_set = 1'b0;
        m_hit = (m_cycle == int'(m_tcmp)) || (m_hit && !(we && ok && r == 2'd2 && d[0]));
        if (m_fifo.size() > 0 && ready) void'(m_fifo.pop_front());
        if (we && ok && r == 2'd3) begin
            if (m_fifo.size() < FIFO_DEPTH) m_fifo.push_back(d);
            else ovf_set = 1'b1;
        end
        m_ovf = ovf_set || (m_ovf && !(we && ok && r == 2'd2 && d[3]));
        if (we && ok && r == 2'd1) m_tcmp = d;
        m_cycle = (m_cycle + 1) % 65536;
        if (we && !is_io(a)) begin
            m_ram[ram_word(a)]   = d;
            m_known[ram_word(a)] = 1'b1;
        end
    endtask

    // One bus cycle: drive, check the combinational read, clock, check registered outputs.
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] d,
                                 input logic oe, input logic we, input logic ready);
        logic [15:0] exp;
        string tag;
        daddr = a; ddout = d; doe = oe; dwe = we; out_ready = ready;
        #1;
        if (!oe) begin
            checkOutput("ddin_idle", ddin, 16'h0000);
        end else if (model_read(a, exp)) begin
            tag = is_io(a) ? "ddin_io" : "ddin_ram";
            checkOutput(tag, ddin, exp);
        end
        @(posedge clk);
        model_edge(a, d, we, ready);
        #1;
        checkOutput("out_valid", {15'd0, out_valid}, {15'd0, m_fifo.size() != 0});
        if (m_fifo.size() != 0) checkOutput("out_data", out_data, m_fifo[0]);
        checkOutput("timer_irq", {15'd0, timer_irq}, {15'd0, m_hit});
        @(negedge clk);
    endtask

    task automatic writeBus(input logic [15:0] a, input logic [15:0] d, input logic ready);
        applyStimulus(a, d, 1'b0, 1'b1, ready);
    endtask

    task automatic readBus(input logic [15:0] a, input logic ready);
        applyStimulus(a, 16'h0000, 1'b1, 1'b0, ready);
    endtask

    task automatic idleCycles(input int n, input logic ready);
        daddr = 16'h0000; ddout = 16'h0000; doe = 1'b0; dwe = 1'b0; out_ready = ready;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge(16'h0000, 16'h0000, 1'b0, ready);
        end
        @(negedge clk);
    endtask

    initial begin
        logic [15:0] t;
        logic [15:0] a;
        int sel;

        for (int i = 0; i < RAM_WORDS; i++) begin
            m_ram[i]   = 16'h0000;
            m_known[i] = 1'b0;
        end
        rst = 1'b1;
        daddr = 16'h0000; ddout = 16'h0000; doe = 1'b0; dwe = 1'b0; out_ready = 1'b0;
        model_reset();
        #2;
        checkOutput("rst_out_valid", {15'd0, out_valid}, 16'h0000);
        checkOutput("rst_timer_irq", {15'd0, timer_irq}, 16'h0000);
        checkOutput("rst_out_data", out_data, 16'h0000);
        daddr = 16'hF004; doe = 1'b1;
        #1;
        checkOutput("rst_status", ddin, 16'h0004);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] RAM round trip and read-during-write");
        writeBus(16'h0010, 16'hBEEF, 1'b0);
        readBus(16'h0010, 1'b0);
        readBus(16'h0011, 1'b0);
        applyStimulus(16'h0010, 16'h0000, 1'b0, 1'b0, 1'b0);
        writeBus(16'h0020, 16'h1111, 1'b0);
        applyStimulus(16'h0020, 16'h2222, 1'b1, 1'b1, 1'b0);
        readBus(16'h0020, 1'b0);

        $display("[TB] Timer compare, W1C and set-wins");
        t = 16'(m_cycle + 5);
        writeBus(16'hF002, t, 1'b0);
        readBus(16'hF002, 1'b0);
        for (int i = 0; i < 8; i++) readBus(16'hF004, 1'b0);
        checkOutput("timer_hit_set", {15'd0, timer_irq}, 16'h0001);
        writeBus(16'hF004, 16'h0001, 1'b0);
        readBus(16'hF004, 1'b0);
        t = 16'(m_cycle + 4);
        writeBus(16'hF002, t, 1'b0);
        for (int i = 0; i < 8 && m_cycle != int'(t); i++) readBus(16'hF000, 1'b0);
        writeBus(16'hF004, 16'h0001, 1'b0);
        checkOutput("timer_set_wins", {15'd0, timer_irq}, 16'h0001);
        readBus(16'hF004, 1'b0);

        $display("[TB] FIFO fill, overflow and drain");
        for (int i = 0; i < 5; i++) begin
            writeBus(16'hF006, 16'(16'h00A0 + i), 1'b0);
            readBus(16'hF004, 1'b0);
        end
        readBus(16'hF006, 1'b0);
        for (int i = 0; i < 6; i++) readBus(16'hF004, 1'b1);
        writeBus(16'hF004, 16'h0008, 1'b0);
        readBus(16'hF004, 1'b0);

        $display("[TB] FIFO push and pop while full");
        for (int i = 0; i < 4; i++) writeBus(16'hF006, 16'(16'h00C0 + i), 1'b0);
        writeBus(16'hF006, 16'h00B0, 1'b1);
        readBus(16'hF004, 1'b0);
        for (int i = 0; i < 6; i++) readBus(16'hF004, 1'b1);

        $display("[TB] Asynchronous reset mid-operation");
        writeBus(16'hF006, 16'h00D1, 1'b0);
        writeBus(16'hF006, 16'h00D2, 1'b0);
        writeBus(16'hF004, 16'h0001, 1'b0);
        t = 16'(m_cycle + 2);
        writeBus(16'hF002, t, 1'b0);
        for (int i = 0; i < 6 && !m_hit; i++) readBus(16'hF004, 1'b0);
        #1 rst = 1'b1;
        model_reset();
        #1;
        checkOutput("mid_rst_out_valid", {15'd0, out_valid}, 16'h0000);
        checkOutput("mid_rst_timer_irq", {15'd0, timer_irq}, 16'h0000);
        checkOutput("mid_rst_out_data", out_data, 16'h0000);
        #1 rst = 1'b0;
        readBus(16'hF004, 1'b0);
        readBus(16'hF000, 1'b0);
        readBus(16'h0010, 1'b0);

        $display("[TB] Random traffic");
        for (int n = 0; n < 400; n++) begin
            sel = int'($urandom_range(0, 7));
            a = 16'($urandom);
            a[15:12] = 4'($urandom_range(0, 14));
            a[RAM_AW:1] = RAM_AW'($urandom_range(0, 31));
            case (sel)
                0: applyStimulus(a, 16'($urandom), 1'($urandom), 1'b1, 1'($urandom));
                1, 2: readBus(a, 1'($urandom));
                3: begin
                    if ($urandom_range(0, 3) == 0) a = 16'hF000 | 16'($urandom_range(1, 511) << 3);
                    else a = 16'hF000 | 16'($urandom_range(0, 3) << 1) | 16'($urandom_range(0, 1));
                    readBus(a, 1'($urandom));
                end
                4: writeBus(16'hF002, 16'(m_cycle + int'($urandom_range(0, 8))), 1'($urandom));
                5: begin
                    a = ($urandom_range(0, 3) == 0) ? 16'hF00C : 16'hF004;
                    writeBus(a, 16'($urandom), 1'($urandom));
                end
                default: applyStimulus(16'hF006, 16'($urandom), 1'($urandom), 1'b1, 1'($urandom));
            endcase
        end

        $display("[TB] Cycle counter wrap");
        idleCycles(65535 - m_cycle, 1'b1);
        readBus(16'hF000, 1'b0);
        readBus(16'hF000, 1'b0);
        checkOutput("cycle_wrapped", 16'(m_cycle), 16'h0001);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
